regfile_wport_arb: RTL and testbench

//  Arbitrates the single regfile write port (we3/wa3/wd3) between the in-order W-stage

---
 rtl/regfile_wport_arb_if.sv | 37 +++
 rtl/regfile_wport_arb.sv | 86 ++++++++
 tb/tb_regfile_wport_arb.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wport_arb_if.sv
// Write-port arbitration bus: W-stage writeback, one async requester,
// the shared regfile write port and the hazard-facing hold status.
interface regfile_wport_arb_if #(
   parameter int AW = 5,
   parameter int DW = 32
);
   logic          stallW;
   logic          pipe_we;
   logic [AW-1:0] pipe_wa;
   logic [DW-1:0] pipe_wd;
   logic          stall_pipe;
   logic          acc_valid;
   logic [AW-1:0] acc_wa;
   logic [DW-1:0] acc_wd;
   logic          acc_ready;
   logic          hold_busy;
   logic [AW-1:0] hold_wa;
   logic          we3;
   logic [AW-1:0] wa3;
   logic [DW-1:0] wd3;

   // Requester side: pipeline and async unit drive requests, observe grants
   modport master (
      output stallW, pipe_we, pipe_wa, pipe_wd,
      output acc_valid, acc_wa, acc_wd,
      input  stall_pipe, acc_ready, hold_busy, hold_wa,
      input  we3, wa3, wd3
   );

   // Arbiter side
   modport slave (
      input  stallW, pipe_we, pipe_wa, pipe_wd,
      input  acc_valid, acc_wa, acc_wd,
      output stall_pipe, acc_ready, hold_busy, hold_wa,
      output we3, wa3, wd3
   );
endinterface

// File: rtl/regfile_wport_arb.sv
// Regfile write-port arbiter. The in-order W-stage writeback normally wins;
// a single held async result (mul/div, miss-load return) takes the port when
// the pipe is idle or once it has lost MAX_WAIT times, stalling W that cycle.
module regfile_wport_arb #(
   parameter int MAX_WAIT = 4,
   parameter int AW       = 5,
   parameter int DW       = 32
) (
   input logic                 clk,
   input logic                 rst,
   regfile_wport_arb_if.slave  bus
);

   logic          hold_v;
   logic [AW-1:0] hold_wa_q;
   logic [DW-1:0] hold_wd;
   logic [3:0]    age;

   logic          pipe_req;
   logic          aged_out;
   logic          g_hold;
   logic          g_pipe;
   logic          accept;

   // Grant decision: r0 writes are not requests, a frozen W stage grants nothing,
   // and the held entry wins when the pipe is idle or its age has hit the limit
   always_comb begin
      pipe_req = bus.pipe_we & (bus.pipe_wa != '0);
      aged_out = (age == 4'(MAX_WAIT));
      g_hold   = 1'b0;
      g_pipe   = 1'b0;
      if (!bus.stallW) begin
         g_hold = hold_v & (!pipe_req | aged_out);
         g_pipe = pipe_req & !g_hold;
      end
      accept = bus.acc_valid & bus.acc_ready;
   end

   // Drive the shared write port and the handshake/status outputs
   always_comb begin
      bus.we3 = g_hold | g_pipe;
      bus.wa3 = '0;
      bus.wd3 = '0;
      if (g_hold) begin
         bus.wa3 = hold_wa_q;
         bus.wd3 = hold_wd;
      end else if (g_pipe) begin
         bus.wa3 = bus.pipe_wa;
         bus.wd3 = bus.pipe_wd;
      end
      bus.stall_pipe = pipe_req & g_hold & !bus.stallW;
      bus.acc_ready  = !hold_v | g_hold;
      bus.hold_busy  = hold_v;
      bus.hold_wa    = hold_v ? hold_wa_q : '0;
   end

   // Hold register and age: refill on accept (same cycle as a drain is fine),
   // clear on drain, and age only when the pipe beats a waiting entry
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_v    <= 1'b0;
         hold_wa_q <= '0;
         hold_wd   <= '0;
         age       <= '0;
      end else if (accept) begin
         if (bus.acc_wa != '0) begin
            hold_v    <= 1'b1;
            hold_wa_q <= bus.acc_wa;
            hold_wd   <= bus.acc_wd;
         end else begin
            hold_v    <= 1'b0;
            hold_wa_q <= '0;
         end
         age <= '0;
      end else if (g_hold) begin
         hold_v    <= 1'b0;
         hold_wa_q <= '0;
         age       <= '0;
      end else if (g_pipe && hold_v) begin
         if (!aged_out) begin
            age <= age + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Directed bench for regfile_wport_arb: the stimulus thread pushes the
// hand-computed outputs expected for each cycle into a queue, and a monitor
// on the falling edge pops and compares them against what the DUT presents.
module tb_regfile_wport_arb;

   localparam int AW = 5;
   localparam int DW = 32;

   typedef struct {
      string         name;
      logic          we3;
      logic [AW-1:0] wa3;
      logic [DW-1:0] wd3;
      logic          stall;
      logic          ready;
      logic          busy;
      logic [AW-1:0] hwa;
   } exp_t;

   logic clk;
   logic rst;
   exp_t expq[$];
   int   testsRun;
   int   testsFailed;
   string curName;

   regfile_wport_arb_if #(.AW(AW), .DW(DW)) bus ();

   regfile_wport_arb #(.MAX_WAIT(4), .AW(AW), .DW(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, period 10
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one expected record against the live DUT outputs
   task automatic checkOutput(input exp_t e);
      logic [AW+AW+DW+4:0] act;
      logic [AW+AW+DW+4:0] req;
      act = {bus.we3, bus.wa3, bus.wd3, bus.stall_pipe, bus.acc_ready, bus.hold_busy, bus.hold_wa};
      req = {e.we3, e.wa3, e.wd3, e.stall, e.ready, e.busy, e.hwa};
      testsRun++;
      if (act !== req) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual we3=%b wa3=%0d wd3=%h stall=%b ready=%b busy=%b hwa=%0d, required we3=%b wa3=%0d wd3=%h stall=%b ready=%b busy=%b hwa=%0d",
                  e.name, bus.we3, bus.wa3, bus.wd3, bus.stall_pipe, bus.acc_ready, bus.hold_busy, bus.hold_wa,
                  e.we3, e.wa3, e.wd3, e.stall, e.ready, e.busy, e.hwa);
      end
   endtask

   // Monitor: one expected record per driven cycle, sampled mid-cycle
   always @(negedge clk) begin
      if (expq.size() > 0) begin
         checkOutput(expq.pop_front());
      end
   end

   // Drive this cycle's inputs (called just after a rising edge)
   task automatic applyStimulus(input string name, input logic r, input logic sw,
                                input logic pwe, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                                input logic av, input logic [AW-1:0] awa, input logic [DW-1:0] awd);
      curName         = name;
      rst             = r;
      bus.stallW      = sw;
      bus.pipe_we     = pwe;
      bus.pipe_wa     = pwa;
      bus.pipe_wd     = pwd;
      bus.acc_valid   = av;
      bus.acc_wa      = awa;
      bus.acc_wd      = awd;
   endtask

   // Queue the outputs expected during this cycle, then advance one clock
   task automatic expectOut(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                            input logic st, input logic rdy, input logic busy, input logic [AW-1:0] hwa);
      exp_t e;
      e.name  = curName;
      e.we3   = we;
      e.wa3   = wa;
      e.wd3   = wd;
      e.stall = st;
      e.ready = rdy;
      e.busy  = busy;
      e.hwa   = hwa;
      expq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Directed sequence
   initial begin
      testsRun    = 0;
      testsFailed = 0;
      applyStimulus("pre", 1, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;

      // Reset state
      applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 0);
      expectOut(0, 0, 0, 0, 1, 0, 0);

      // Plain pipe write goes straight through
      applyStimulus("pipe_wr", 0, 0, 1, 3, 32'h11, 0, 0, 0);
      expectOut(1, 3, 32'h11, 0, 1, 0, 0);

      // Async accept with idle pipe, written next cycle, then empty
      applyStimulus("acc_load", 0, 0, 0, 0, 0, 1, 7, 32'hAB);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      applyStimulus("acc_drain", 0, 0, 0, 0, 0, 0, 0, 0);
      expectOut(1, 7, 32'hAB, 0, 1, 1, 7);
      applyStimulus("acc_empty", 0, 0, 0, 0, 0, 0, 0, 0);
      expectOut(0, 0, 0, 0, 1, 0, 0);

      // Aging: pipe wins 4 times, then the hold forces its way in
      applyStimulus("age_load", 0, 0, 0, 0, 0, 1, 7, 32'hCD);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("age_pipe%0d", i), 0, 0, 1, 5, 32'h100 + i, 0, 0, 0);
         expectOut(1, 5, 32'h100 + i, 0, 0, 1, 7);
      end
      applyStimulus("age_force", 0, 0, 1, 5, 32'h105, 0, 0, 0);
      expectOut(1, 7, 32'hCD, 1, 1, 1, 7);
      applyStimulus("age_retry", 0, 0, 1, 5, 32'h105, 0, 0, 0);
      expectOut(1, 5, 32'h105, 0, 1, 0, 0);

      // stallW freezes grants and age; an offered async result is refused
      applyStimulus("stw_load", 0, 0, 0, 0, 0, 1, 12, 32'hEE);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 2; i++) begin
         applyStimulus($sformatf("stw_pre%0d", i), 0, 0, 1, 6, 32'h66, 0, 0, 0);
         expectOut(1, 6, 32'h66, 0, 0, 1, 12);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus($sformatf("stw_frozen%0d", i), 0, 1, 1, 6, 32'h66, 1, 13, 32'hDD);
         expectOut(0, 0, 0, 0, 0, 1, 12);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus($sformatf("stw_post%0d", i), 0, 0, 1, 6, 32'h66, 0, 0, 0);
         expectOut(1, 6, 32'h66, 0, 0, 1, 12);
      end
      applyStimulus("stw_force", 0, 0, 1, 6, 32'h66, 0, 0, 0);
      expectOut(1, 12, 32'hEE, 1, 1, 1, 12);
      applyStimulus("stw_retry", 0, 0, 1, 6, 32'h66, 0, 0, 0);
      expectOut(1, 6, 32'h66, 0, 1, 0, 0);

      // Drain and refill in the same cycle, then discard of r0 results
      applyStimulus("refill_load", 0, 0, 0, 0, 0, 1, 3, 32'h33);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      applyStimulus("refill_swap", 0, 0, 0, 0, 0, 1, 9, 32'h99);
      expectOut(1, 3, 32'h33, 0, 1, 1, 3);
      applyStimulus("refill_r0drop", 0, 0, 0, 0, 0, 1, 0, 32'h77);
      expectOut(1, 9, 32'h99, 0, 1, 1, 9);
      applyStimulus("r0_empty_acc", 0, 0, 0, 0, 0, 1, 0, 32'h78);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      applyStimulus("r0_stays_empty", 0, 0, 1, 0, 32'h55, 0, 0, 0);
      expectOut(0, 0, 0, 0, 1, 0, 0);

      // Pipe write to r0 with a hold pending: no request, hold wins, no stall
      applyStimulus("r0pipe_load", 0, 0, 1, 0, 32'h55, 1, 10, 32'hA0);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      applyStimulus("r0pipe_hold", 0, 0, 1, 0, 32'h55, 0, 0, 0);
      expectOut(1, 10, 32'hA0, 0, 1, 1, 10);

      // Reset mid-operation drops the held write and clears age
      applyStimulus("rst_load", 0, 0, 0, 0, 0, 1, 14, 32'hE4);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus($sformatf("rst_age%0d", i), 0, 0, 1, 6, 32'h60 + i, 0, 0, 0);
         expectOut(1, 6, 32'h60 + i, 0, 0, 1, 14);
      end
      applyStimulus("rst_assert", 1, 0, 1, 6, 32'h63, 0, 0, 0);
      expectOut(1, 6, 32'h63, 0, 0, 1, 14);
      applyStimulus("rst_after", 0, 0, 0, 0, 0, 0, 0, 0);
      expectOut(0, 0, 0, 0, 1, 0, 0);

      // After reset a fresh hold must survive a full 4 pipe wins again
      applyStimulus("rst_reload", 0, 0, 0, 0, 0, 1, 15, 32'hF5);
      expectOut(0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("rst_pipe%0d", i), 0, 0, 1, 2, 32'h20 + i, 0, 0, 0);
         expectOut(1, 2, 32'h20 + i, 0, 0, 1, 15);
      end
      applyStimulus("rst_force", 0, 0, 1, 2, 32'h24, 0, 0, 0);
      expectOut(1, 15, 32'hF5, 1, 1, 1, 15);
      applyStimulus("idle_end", 0, 0, 0, 0, 0, 0, 0, 0);
      expectOut(0, 0, 0, 0, 1, 0, 0);

      // Let the monitor drain the queue, bounded
      for (int i = 0; i < 10 && expq.size() > 0; i++) begin
         @(posedge clk);
      end
      if (expq.size() > 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: actual %0d records left, required 0", expq.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
